// File: rtl/counter_report_pkg.sv
// counter_report_pkg: shared FSM states, message bytes and sizing helpers for counter_report_tx
package counter_report_pkg;
  typedef enum logic [2:0] {IDLE, CONV, PRESENT, WAIT_RD, GAP} state_t;
  localparam logic [7:0] CH_C = 8'h43;
  localparam logic [7:0] CH_N = 8'h4E;
  localparam logic [7:0] CH_T = 8'h54;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam int PREFIX_LEN = 5;
  function automatic logic [7:0] prefix_byte(int i);
    return i == 0 ? CH_C : i == 1 ? CH_N : i == 2 ? CH_T : i == 3 ? CH_COLON : CH_SP;
  endfunction
  function automatic int msg_len(int digits);
    return PREFIX_LEN + digits + 2;
  endfunction
  function automatic int min_digits(int w);
    longint unsigned m;
    int d;
    m = (64'd1 << w) - 64'd1;
    d = 1;
    while (m >= 64'd10) begin
      m = m / 64'd10;
      d++;
    end
    return d;
  endfunction
endpackage

// File: rtl/counter_report_tx_if.sv
// counter_report_tx_if: byte handshake between the report generator and uart_tx
interface counter_report_tx_if;
  logic [7:0] din;
  logic empty;
  logic re;
  modport master (output din, output empty, input re);
  modport slave (input din, input empty, output re);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one input bit per cycle, done W cycles after start
module bin2bcd_seq #(
  parameter int W = 6,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * DIGITS;
  logic [W-1:0] sh_q;
  logic [BW-1:0] bcd_q, adj;
  logic [CW-1:0] cnt_q;
  logic done_q;
  // add-3 correction on every digit of 5 or more before the next shift
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] + (bcd_q[4*i +: 4] >= 4'd5 ? 4'd3 : 4'd0);
  end
  // the load cycle already shifts in the first bit, so W-1 further steps remain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
    end else if (start) begin
      sh_q <= bin << 1;
      bcd_q <= BW'(bin[W-1]);
      cnt_q <= CW'(W - 1);
      done_q <= (W == 1);
    end else if (cnt_q != '0) begin
      sh_q <= sh_q << 1;
      bcd_q <= (adj << 1) | BW'(sh_q[W-1]);
      cnt_q <= cnt_q - 1'b1;
      done_q <= cnt_q == CW'(1);
    end else begin
      done_q <= 1'b0;
    end
  end
  assign done = done_q;
  assign bcd = bcd_q;
endmodule

// File: rtl/counter_report_tx.sv
// counter_report_tx: up/down counter that reports its value as "CNT: <digits>\r\n" to uart_tx
module counter_report_tx
  import counter_report_pkg::*;
#(
  parameter int CNT_WIDTH = 6,
  parameter int DIGITS = 2,
  parameter bit WRAP = 1'b1,
  parameter bit REPORT_ON_CLR = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 busy,
  output logic                 pending,
  counter_report_tx_if.master  tx
);
  localparam int ML = msg_len(DIGITS);
  localparam int IW = $clog2(ML);
  localparam logic [CNT_WIDTH-1:0] MAXV = '1;
  if (DIGITS < min_digits(CNT_WIDTH)) begin : g_digits_chk
    $error("DIGITS too small for CNT_WIDTH");
  end
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CNT_WIDTH-1:0] count_q, count_d, up, dn;
  logic [7:0] din_q, din_d, msg_byte;
  logic empty_q, empty_d, pending_q, pending_d, re_q;
  logic ev, start, done, re_rise, last;
  logic [4*DIGITS-1:0] bcd;
  bin2bcd_seq #(.W(CNT_WIDTH), .DIGITS(DIGITS)) u_b2b (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(count_d), .done(done), .bcd(bcd)
  );
  // counter next value; held bounds in saturate mode are not changes
  always_comb begin
    up = (!WRAP && count_q == MAXV) ? count_q : count_q + 1'b1;
    dn = (!WRAP && count_q == '0) ? count_q : count_q - 1'b1;
    count_d = clr ? '0 : (inc ^ dec) ? (inc ? up : dn) : count_q;
    ev = (count_d != count_q) || (clr && REPORT_ON_CLR);
  end
  // byte at the current message index; digits are taken most significant first
  always_comb begin
    msg_byte = idx_q == IW'(ML - 2) ? CH_CR : idx_q == IW'(ML - 1) ? CH_LF : prefix_byte(int'(idx_q));
    for (int k = 0; k < DIGITS; k++)
      if (idx_q == IW'(PREFIX_LEN + k)) msg_byte = CH_ZERO | {4'h0, bcd[4*(DIGITS-1-k) +: 4]};
  end
  assign re_rise = tx.re & ~re_q;
  assign last = idx_q == IW'(ML - 1);
  // report FSM; a new conversion always snapshots the post-update count
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    din_d = din_q;
    empty_d = empty_q;
    start = 1'b0;
    case (state_q)
      IDLE: if (ev) begin
        start = 1'b1;
        state_d = CONV;
      end
      CONV: if (done) begin
        idx_d = '0;
        state_d = PRESENT;
      end
      PRESENT: begin
        din_d = msg_byte;
        empty_d = 1'b0;
        state_d = WAIT_RD;
      end
      WAIT_RD: if (re_rise) begin
        empty_d = 1'b1;
        state_d = GAP;
      end
      GAP: if (!last) begin
        idx_d = idx_q + 1'b1;
        state_d = PRESENT;
      end else if (pending_q || ev) begin
        start = 1'b1;
        state_d = CONV;
      end else begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    pending_d = start ? 1'b0 : (state_q != IDLE && ev) ? 1'b1 : pending_q;
  end
  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      count_q <= '0;
      din_q <= 8'h00;
      empty_q <= 1'b1;
      pending_q <= 1'b0;
      re_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      count_q <= count_d;
      din_q <= din_d;
      empty_q <= empty_d;
      pending_q <= pending_d;
      re_q <= tx.re;
    end
  end
  assign count = count_q;
  assign busy = state_q != IDLE;
  assign pending = pending_q;
  assign tx.din = din_q;
  assign tx.empty = empty_q;
endmodule

// File: tb/tb_counter_report_tx.sv
// tb_counter_report_tx: scoreboard bench for counter_report_tx with a uart_tx read model
module tb_counter_report_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic inc0 = 0, dec0 = 0, clr0 = 0, inc1 = 0, dec1 = 0, clr1 = 0, inc2 = 0, dec2 = 0, clr2 = 0;
  logic [5:0] count0, count1;
  logic [9:0] count2;
  logic busy0, busy1, busy2, pend0, pend1, pend2;
  counter_report_tx_if if0 ();
  counter_report_tx_if if1 ();
  counter_report_tx_if if2 ();
  counter_report_tx dut0 (.clk(clk), .rst_n(rst_n), .inc(inc0), .dec(dec0), .clr(clr0),
    .count(count0), .busy(busy0), .pending(pend0), .tx(if0.master));
  counter_report_tx #(.WRAP(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .inc(inc1), .dec(dec1), .clr(clr1),
    .count(count1), .busy(busy1), .pending(pend1), .tx(if1.master));
  counter_report_tx #(.CNT_WIDTH(10), .DIGITS(4)) dut2 (.clk(clk), .rst_n(rst_n), .inc(inc2), .dec(dec2), .clr(clr2),
    .count(count2), .busy(busy2), .pending(pend2), .tx(if2.master));

  int errors = 0, checks = 0;
  logic [7:0] q0[$], q2[$];
  int nb0 = 0, nb2 = 0, rc0 = 0, rc2 = 0;
  logic pe0 = 1, pe2 = 1;
  logic [7:0] e0, e2;
  bit en2 = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_msg(int which, int v, int nd);
    logic [7:0] m[$];
    m = '{8'h43, 8'h4E, 8'h54, 8'h3A, 8'h20};
    for (int k = nd - 1; k >= 0; k--) m.push_back(8'h30 + 8'((v / (10 ** k)) % 10));
    m.push_back(8'h0D);
    m.push_back(8'h0A);
    foreach (m[i]) if (which == 0) q0.push_back(m[i]); else q2.push_back(m[i]);
  endtask

  // uart_tx model and monitor for dut0: check each presented byte, pulse re 10 cycles later
  always @(negedge clk) begin
    if (!rst_n) begin
      pe0 = 1; rc0 = 0; if0.re = 0;
    end else begin
      if0.re = 0;
      if (pe0 && !if0.empty) begin
        checks++; nb0++; rc0 = 10;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL dut0 byte: got %02h, expected no byte", if0.din);
        end else begin
          e0 = q0.pop_front();
          if (if0.din !== e0) begin
            errors++;
            $display("FAIL dut0 byte %0d: got %02h, expected %02h", nb0, if0.din, e0);
          end
        end
      end else if (rc0 > 0) begin
        rc0--;
        if (rc0 == 0) if0.re = 1;
      end
      pe0 = if0.empty;
    end
  end

  // uart_tx model and monitor for dut2; reads are held off until en2
  always @(negedge clk) begin
    if (!rst_n) begin
      pe2 = 1; rc2 = 0; if2.re = 0;
    end else begin
      if2.re = 0;
      if (pe2 && !if2.empty) begin
        checks++; nb2++; rc2 = 10;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL dut2 byte: got %02h, expected no byte", if2.din);
        end else begin
          e2 = q2.pop_front();
          if (if2.din !== e2) begin
            errors++;
            $display("FAIL dut2 byte %0d: got %02h, expected %02h", nb2, if2.din, e2);
          end
        end
      end else if (rc2 > 0 && en2) begin
        rc2--;
        if (rc2 == 0) if2.re = 1;
      end
      pe2 = if2.empty;
    end
  end

  task automatic pulse0(bit i, bit d, bit c);
    @(negedge clk); inc0 = i; dec0 = d; clr0 = c;
    @(negedge clk); inc0 = 0; dec0 = 0; clr0 = 0;
  endtask

  task automatic wait_done0(string name);
    int n = 0;
    while ((q0.size() != 0 || busy0) && n < 3000) begin @(negedge clk); n++; end
    chk(name, (q0.size() == 0 && !busy0), 1);
  endtask

  task automatic wait_bytes0(int n);
    int t = 0;
    while (nb0 < n && t < 2000) begin @(negedge clk); t++; end
    if (nb0 < n) begin
      checks++; errors++;
      $display("FAIL wait for byte %0d: got %0d bytes, expected %0d", n, nb0, n);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, base, seen, n;
    if1.re = 0;
    repeat (3) @(negedge clk);
    chk("reset count", count0, 0);
    chk("reset empty", if0.empty, 1);
    chk("reset din", if0.din, 0);
    chk("reset busy", busy0, 0);
    chk("reset pending", pend0, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    // single inc from 0, conversion latency of 6 cycles plus PRESENT and register stage
    push_msg(0, 1, 2);
    @(negedge clk); inc0 = 1;
    @(negedge clk); inc0 = 0; lat = 1;
    chk("count after inc", count0, 1);
    chk("busy during report", busy0, 1);
    while (if0.empty && lat < 50) begin @(negedge clk); lat++; end
    chk("inc to first byte latency", lat, 8);
    wait_done0("first report done");
    chk("busy back to 0", busy0, 0);
    // wrap at both ends
    push_msg(0, 0, 2); pulse0(0, 1, 0); chk("dec to 0", count0, 0); wait_done0("report 00");
    push_msg(0, 63, 2); pulse0(0, 1, 0); chk("wrap below 0", count0, 63); wait_done0("report 63");
    push_msg(0, 0, 2); pulse0(1, 0, 0); chk("wrap above max", count0, 0); wait_done0("report wrap 00");
    // saturating instance: dec at 0 holds and stays silent
    @(negedge clk); dec1 = 1;
    @(negedge clk); dec1 = 0; seen = 0;
    repeat (20) begin @(negedge clk); if (!if1.empty || busy1) seen = 1; end
    chk("wrap0 dec at 0 silent", seen, 0);
    chk("wrap0 count held", count1, 0);
    // changes during a report coalesce into one follow-up
    push_msg(0, 1, 2); push_msg(0, 3, 2); base = nb0;
    pulse0(1, 0, 0);
    wait_bytes0(base + 2); pulse0(1, 0, 0);
    chk("pending after mid inc", pend0, 1);
    wait_bytes0(base + 6); pulse0(1, 0, 0);
    chk("count after coalesce", count0, 3);
    wait_done0("coalesced reports done");
    repeat (40) @(negedge clk);
    chk("no extra report", busy0, 0);
    // inc and dec together
    pulse0(1, 1, 0);
    chk("inc+dec count", count0, 3);
    repeat (20) @(negedge clk);
    chk("inc+dec no report", busy0, 0);
    // clr at 5, then clr at 0 still reports
    push_msg(0, 4, 2); pulse0(1, 0, 0); wait_done0("report 04");
    push_msg(0, 5, 2); pulse0(1, 0, 0); wait_done0("report 05");
    chk("count 5", count0, 5);
    push_msg(0, 0, 2); pulse0(0, 0, 1); chk("clr count", count0, 0); wait_done0("clr report");
    push_msg(0, 0, 2); pulse0(0, 0, 1); wait_done0("clr at 0 report");
    // wide instance: 10-cycle conversion, 1023 after coalescing
    push_msg(2, 1, 4); push_msg(2, 1023, 4);
    @(negedge clk); inc2 = 1;
    @(negedge clk); inc2 = 0; lat = 1;
    while (if2.empty && lat < 50) begin @(negedge clk); lat++; end
    chk("wide latency", lat, 12);
    for (int i = 0; i < 1022; i++) begin @(negedge clk); inc2 = 1; end
    @(negedge clk); inc2 = 0;
    chk("wide count 1023", count2, 1023);
    chk("wide pending", pend2, 1);
    en2 = 1; n = 0;
    while ((q2.size() != 0 || busy2) && n < 3000) begin @(negedge clk); n++; end
    chk("wide reports done", (q2.size() == 0 && !busy2), 1);
    // asynchronous reset while byte 4 waits for its read
    push_msg(0, 1, 2); base = nb0;
    pulse0(1, 0, 0);
    wait_bytes0(base + 4);
    #2 rst_n = 0;
    #1;
    chk("async reset empty", if0.empty, 1);
    chk("async reset count", count0, 0);
    chk("async reset busy", busy0, 0);
    q0.delete();
    repeat (3) @(negedge clk);
    rst_n = 1; seen = 0;
    repeat (40) begin @(negedge clk); if (!if0.empty || busy0) seen = 1; end
    chk("idle after reset", seen, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
